// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the binarized fully-connected layer scheduler:
//   - state_t     : scheduler FSM state encoding
//   - WORD_W_DEF  : default packed-bit word width
//   - ACC_W       : width of the signed dot-product accumulator / threshold
//   - min1_clog2  : index width helper that never returns zero
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int ACC_W      = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  // Counter width for a range of 'value' entries; a 1-entry range still
  // needs a 1-bit vector so that port and register declarations stay legal.
  function automatic int min1_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/bnn_rd_align.sv
// -----------------------------------------------------------------------------
// bnn_rd_align
// Delays the read-enable / last-word qualifiers by one cycle so they line up
// with the 1-cycle-latency memory read data, and gates the operand words to
// zero outside valid word cycles.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rd_en, rd_last        : read issued this cycle / it is the last word
//   a_data, w_data        : activation / weight memory read data
//   word_valid, last_word : qualifiers aligned with the read data
//   a_word, w_word        : operand words, zero when word_valid is low
// -----------------------------------------------------------------------------
module bnn_rd_align #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              rd_last,
  input  logic [WORD_W-1:0] a_data,
  input  logic [WORD_W-1:0] w_data,
  output logic              word_valid,
  output logic              last_word,
  output logic [WORD_W-1:0] a_word,
  output logic [WORD_W-1:0] w_word
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      last_word  <= 1'b0;
    end else begin
      word_valid <= rd_en;
      last_word  <= rd_en & rd_last;
    end
  end

  // Memory outputs hold stale data between reads; keep the dot unit inputs
  // clean so nothing downstream depends on idle read data.
  assign a_word = word_valid ? a_data : '0;
  assign w_word = word_valid ? w_data : '0;

endmodule

// File: rtl/bnn_fc_sched.sv
// -----------------------------------------------------------------------------
// bnn_fc_sched
// Scheduler for one binarized fully-connected layer. For each of N_OUT output
// neurons it clears an external dot unit, streams N_WORDS activation/weight
// word pairs from two 1-cycle-latency memories, waits for the dot result and
// emits it together with a thresholded output bit.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cfg_start, cfg_thr         : start pulse and signed threshold (IDLE only)
//   abort                      : synchronous cancel of a running layer
//   busy, layer_done           : layer in progress / one-cycle completion
//   act_rd_en, act_rd_addr     : activation memory read (address = word k)
//   act_rd_data                : activation data, 1 cycle after act_rd_en
//   w_rd_en, w_rd_addr         : weight memory read (address = n*N_WORDS+k)
//   w_rd_data                  : weight data, 1 cycle after w_rd_en
//   dot_start                  : clears the dot-unit accumulator
//   dot_a_word, dot_w_word     : operand words
//   dot_word_valid, dot_last_word : operand qualifiers
//   dot_done, dot_acc          : dot result handshake from the dot unit
//   out_valid, out_idx, out_bit, out_acc : per-neuron result pulse
// -----------------------------------------------------------------------------
module bnn_fc_sched
  import bnn_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int N_WORDS = 2,
  parameter int N_OUT   = 16,
  parameter int AW      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic signed [ACC_W-1:0]       cfg_thr,
  input  logic                          abort,
  output logic                          busy,
  output logic                          layer_done,
  output logic                          act_rd_en,
  output logic [AW-1:0]                 act_rd_addr,
  input  logic [WORD_W-1:0]             act_rd_data,
  output logic                          w_rd_en,
  output logic [AW-1:0]                 w_rd_addr,
  input  logic [WORD_W-1:0]             w_rd_data,
  output logic                          dot_start,
  output logic [WORD_W-1:0]             dot_a_word,
  output logic [WORD_W-1:0]             dot_w_word,
  output logic                          dot_word_valid,
  output logic                          dot_last_word,
  input  logic                          dot_done,
  input  logic signed [ACC_W-1:0]       dot_acc,
  output logic                          out_valid,
  output logic [min1_clog2(N_OUT)-1:0]  out_idx,
  output logic                          out_bit,
  output logic signed [ACC_W-1:0]       out_acc
);

  localparam int IDX_W = min1_clog2(N_OUT);
  localparam int KW    = min1_clog2(N_WORDS);

  localparam logic [KW-1:0]    K_LAST = KW'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N_OUT - 1);

  // Every weight word must be addressable without wrap-around.
  localparam longint ADDR_SPACE = longint'(1) << AW;
  if (longint'(N_OUT) * longint'(N_WORDS) > ADDR_SPACE) begin : g_addr_check
    $error("bnn_fc_sched: N_OUT*N_WORDS exceeds the AW-bit address space");
  end

  state_t                   state;
  logic signed [ACC_W-1:0]  thr;
  logic [IDX_W-1:0]         n;
  logic [KW-1:0]            k;
  logic                     rd_en;
  logic                     rd_last;

  assign act_rd_en   = rd_en;
  assign w_rd_en     = rd_en;
  assign act_rd_addr = AW'(k);
  assign w_rd_addr   = AW'(AW'(n) * AW'(N_WORDS) + AW'(k));
  assign rd_last     = (k == K_LAST);

  // Outputs are registered on the transition into the state that owns them,
  // so dot_start is high during START, rd_en during FETCH, out_valid during
  // EMIT and layer_done during FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      thr        <= '0;
      n          <= '0;
      k          <= '0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      rd_en      <= 1'b0;
      dot_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_bit    <= 1'b0;
      out_acc    <= '0;
    end else begin
      dot_start  <= 1'b0;
      out_valid  <= 1'b0;
      layer_done <= 1'b0;

      if (abort && (state != S_IDLE)) begin
        // Pending pulses were already defaulted low above; a dot_done that
        // trails the abort lands in IDLE and is ignored there.
        state <= S_IDLE;
        busy  <= 1'b0;
        rd_en <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_start) begin
              thr       <= cfg_thr;
              n         <= '0;
              busy      <= 1'b1;
              dot_start <= 1'b1;
              state     <= S_START;
            end
          end
          S_START: begin
            k     <= '0;
            rd_en <= 1'b1;
            state <= S_FETCH;
          end
          S_FETCH: begin
            if (rd_last) begin
              rd_en <= 1'b0;
              state <= S_WAIT;
            end else begin
              k <= k + 1'b1;
            end
          end
          S_WAIT: begin
            if (dot_done) begin
              // Compare against dot_acc directly: it is the value out_acc
              // holds during EMIT, so out_bit matches out_acc >= thr.
              out_acc   <= dot_acc;
              out_bit   <= (dot_acc >= thr);
              out_idx   <= n;
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (n == N_LAST) begin
              layer_done <= 1'b1;
              state      <= S_FIN;
            end else begin
              n         <= n + 1'b1;
              dot_start <= 1'b1;
              state     <= S_START;
            end
          end
          S_FIN: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  bnn_rd_align #(
    .WORD_W (WORD_W)
  ) u_rd_align (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_last    (rd_last),
    .a_data     (act_rd_data),
    .w_data     (w_rd_data),
    .word_valid (dot_word_valid),
    .last_word  (dot_last_word),
    .a_word     (dot_a_word),
    .w_word     (dot_w_word)
  );

endmodule

// File: doc/bnn_fc_sched.md
BNN_FC_SCHED -- requirements
Module: bnn_fc_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): WORD_W, 32, packed-bit word width; N_WORDS, 2, words per dot product; N_OUT, 16, output neurons per layer; AW, 16, memory address width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_start, in, 1, pulse that starts a layer.
- cfg_thr, in, 32, signed threshold, sampled on accepted cfg_start.
- abort, in, 1, synchronous cancel.
- busy, out, 1, layer in progress.
- layer_done, out, 1, one-cycle completion pulse.
- act_rd_en / act_rd_addr, out, 1/AW, activation memory read.
- act_rd_data, in, WORD_W, activation data, valid 1 cycle after act_rd_en.
- w_rd_en / w_rd_addr, out, 1/AW, weight memory read.
- w_rd_data, in, WORD_W, weight data, valid 1 cycle after w_rd_en.
- dot_start, out, 1, clears the dot-unit accumulator.
- dot_a_word / dot_w_word, out, WORD_W, operand words.
- dot_word_valid / dot_last_word, out, 1/1, word qualifiers.
- dot_done, in, 1, dot result valid.
- dot_acc, in, 32, signed dot result.
- out_valid, out, 1, one-cycle result pulse.
- out_idx, out, clog2(N_OUT), neuron index.
- out_bit, out, 1, binarized output.
- out_acc, out, 32, signed raw accumulator.

Function
REQ-003 The FSM SHALL have states IDLE, START, FETCH, WAIT, EMIT and FIN.
REQ-004 In IDLE, cfg_start=1 SHALL latch cfg_thr, clear the neuron index n, set busy and go to START. cfg_start SHALL be ignored in every other state.
REQ-005 START SHALL assert dot_start for exactly one cycle, clear the word counter k and go to FETCH.
REQ-006 FETCH SHALL assert act_rd_en and w_rd_en on N_WORDS consecutive cycles (k=0..N_WORDS-1), with act_rd_addr=k and w_rd_addr=n*N_WORDS+k, then go to WAIT.
REQ-007 dot_word_valid and dot_last_word SHALL be rd_en and (k==N_WORDS-1) registered by one cycle. dot_a_word and dot_w_word SHALL be act_rd_data and w_rd_data passed through in that same cycle.
REQ-008 Outside valid word cycles, dot_a_word and dot_w_word SHALL be driven to zero.
REQ-009 In WAIT, dot_done=1 SHALL capture dot_acc into out_acc and go to EMIT. dot_done seen in any other state SHALL be ignored.
REQ-010 EMIT SHALL pulse out_valid for one cycle, with out_idx=n and out_bit=(out_acc >= thr), using a signed 32-bit compare.
REQ-011 After EMIT, if n==N_OUT-1 the FSM SHALL go to FIN; otherwise it SHALL increment n and go to START.
REQ-012 FIN SHALL pulse layer_done for one cycle, clear busy and return to IDLE.
REQ-013 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, clear busy and suppress out_valid and layer_done. A dot_done that arrives later SHALL be ignored.
REQ-014 The minimum time per neuron SHALL be 1 (START) + N_WORDS (FETCH) + 1 (data) + dot latency + 1 (EMIT) cycles. There SHALL be no timeout on WAIT.
REQ-015 Address arithmetic SHALL be AW bits wide. N_OUT*N_WORDS > 2**AW SHALL be flagged as an elaboration error.

Reset
REQ-016 While rst_n=0, state SHALL be IDLE and all outputs and counters SHALL be 0. This includes busy, layer_done, all rd_en, dot_start, dot_word_valid, dot_last_word, out_valid, out_idx, out_bit and out_acc.
REQ-017 rst_n deassertion mid-layer SHALL resume in IDLE with no stale out_valid or layer_done pulse.

Structure
REQ-018 A shared package bnn_pkg SHALL hold the FSM state type, the WORD_W default and the 32-bit accumulator width constant.
REQ-019 A single sub-module, bnn_rd_align, SHALL implement the one-cycle valid/last delay that aligns qualifiers with memory read data.
REQ-020 The dot unit SHALL be instantiated outside this block.

Verification
REQ-021 Bench setup: dot unit plus 1-cycle-latency memories, N_WORDS=2, N_OUT=2. Activations are 0xFFFFFFFF and 0xFFFFFFFF. Neuron 0 weights are 0xFFFFFFFF and 0xFFFFFFFF. Neuron 1 weights are 0xFFFFFFFF and 0x00000000. The bench SHALL cover these scenarios:
- Basic layer: cfg_thr=0 -> out (idx0, acc 64, bit 1), then (idx1, acc 0, bit 1), then one layer_done pulse.
- Threshold boundary: same data with cfg_thr=1 -> idx0 bit 1, idx1 bit 0. cfg_thr=65 -> both bits 0.
- Handshake timing: check w_rd_addr sequence 0,1,2,3. Check dot_last_word high only on the 2nd word of each neuron. Check dot_start exactly once per neuron, before the first dot_word_valid.
- Abort: abort during neuron 1 WAIT -> busy=0 next cycle, no out_valid for idx1, no layer_done. A following cfg_start completes both neurons normally.
- Ignored start: cfg_start pulsed while busy -> no restart, exactly 2 out_valid pulses. Changing cfg_thr mid-layer has no effect on results.
- Reset: assert rst_n=0 during FETCH -> all outputs 0 immediately. After release, the block stays IDLE until cfg_start.
